// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add or shift-subtract step per cycle,
// with the result tagged by a destination register for write-back.
module muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   input  logic [3:0]       DestReg,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic [3:0]       ResultReg,
   output logic             DivByZero
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state;
   logic [4:0]         cnt;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   b_q;
   logic [3:0]         dest_q;
   // Shared accumulator: {product high, product low} or {remainder, quotient}.
   logic [2*WIDTH-1:0] acc;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] step_acc;

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? b_q : {WIDTH{1'b0}})};
      div_shift = acc[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, b_q};
      div_ge    = (div_shift >= {1'b0, b_q});
      // A zero divisor always subtracts, leaving all-ones quotient and the dividend as remainder.
      if (op_q[1])
         step_acc = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
      else
         step_acc = {mul_sum, acc[WIDTH-1:1]};
   end

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state     <= IDLE;
         cnt       <= '0;
         op_q      <= '0;
         b_q       <= '0;
         dest_q    <= '0;
         acc       <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Result    <= '0;
         ResultReg <= '0;
         DivByZero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               Done <= 1'b0;
               if (Start) begin
                  op_q   <= Op;
                  b_q    <= OpB;
                  dest_q <= DestReg;
                  acc    <= {{WIDTH{1'b0}}, OpA};
                  cnt    <= 5'(WIDTH);
                  state  <= RUN;
                  Busy   <= 1'b1;
               end else begin
                  state <= IDLE;
                  Busy  <= 1'b0;
               end
            end
            RUN: begin
               if (cnt != 5'd0) begin
                  acc <= step_acc;
                  cnt <= cnt - 5'd1;
               end else begin
                  state     <= DONE;
                  Busy      <= 1'b0;
                  Done      <= 1'b1;
                  Result    <= op_q[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
                  ResultReg <= dest_q;
                  DivByZero <= op_q[1] && (b_q == '0);
               end
            end
            default: begin
               state <= IDLE;
               Busy  <= 1'b0;
               Done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected results computed with plain
// arithmetic; a monitor pops and compares on every Done pulse, including latency.
module tb_muldiv_unit;

   localparam int WIDTH = 16;

   logic             Clk = 1'b0;
   logic             Rst = 1'b1;
   logic             Start = 1'b0;
   logic [1:0]       Op = '0;
   logic [WIDTH-1:0] OpA = '0;
   logic [WIDTH-1:0] OpB = '0;
   logic [3:0]       DestReg = '0;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Result;
   logic [3:0]       ResultReg;
   logic             DivByZero;

   muldiv_unit #(.WIDTH(WIDTH)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
      .DestReg(DestReg), .Busy(Busy), .Done(Done), .Result(Result),
      .ResultReg(ResultReg), .DivByZero(DivByZero)
   );

   initial forever #5 Clk = ~Clk;

   typedef struct {
      logic [WIDTH-1:0] res;
      logic [3:0]       rreg;
      logic             dbz;
      int               done_cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   done_seen = 0;
   logic prev_done = 1'b0;
   logic prev_busy = 1'b0;

   always @(posedge Clk) cyc = cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
      logic [2*WIDTH-1:0] p;
      p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      case (op)
         2'd0:    return p[WIDTH-1:0];
         2'd1:    return p[2*WIDTH-1:WIDTH];
         2'd2:    return (b == 0) ? {WIDTH{1'b1}} : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Monitor: every Done must match the oldest outstanding expectation.
   always @(negedge Clk) begin
      if (Done) begin
         done_seen++;
         check("done_not_back_to_back", {31'b0, prev_done}, 0);
         check("busy_before_done", {31'b0, prev_busy}, 1);
         check("busy_low_at_done", {31'b0, Busy}, 0);
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result", {16'b0, Result}, {16'b0, e.res});
            check("result_reg", {28'b0, ResultReg}, {28'b0, e.rreg});
            check("div_by_zero", {31'b0, DivByZero}, {31'b0, e.dbz});
            check("latency", cyc, e.done_cyc);
         end
      end
      prev_done = Done;
      prev_busy = Busy;
   end

   // Drive a request at the current (negedge) time; caller guarantees the DUT is IDLE or DONE.
   task automatic launch(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [3:0] dest, input bit push);
      Op = op; OpA = a; OpB = b; DestReg = dest; Start = 1'b1;
      @(posedge Clk);
      #1;
      if (push) begin
         q.push_back('{res: model(op, a, b), rreg: dest, dbz: op[1] && (b == 0),
                       done_cyc: cyc + WIDTH + 1});
         check("busy_after_accept", {31'b0, Busy}, 1);
      end
      @(negedge Clk);
      Start = 1'b0;
      OpA = WIDTH'($urandom); OpB = WIDTH'($urandom);
      Op = 2'($urandom); DestReg = 4'($urandom);
   endtask

   task automatic wait_idle();
      int n;
      for (n = 0; n < 100; n++) begin
         @(negedge Clk);
         if (q.size() == 0 && !Busy && !Done) break;
      end
      if (n == 100) check("wait_idle_timeout", 1, 0);
   endtask

   task automatic wait_done();
      int n;
      for (n = 0; n < 40; n++) begin
         if (Done) break;
         @(negedge Clk);
      end
      if (n == 40) check("wait_done_timeout", 1, 0);
   endtask

   task automatic run_one(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [3:0] dest);
      wait_idle();
      launch(op, a, b, dest, 1'b1);
      wait_idle();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcount;
      repeat (3) @(negedge Clk);
      Start = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      Start = 1'b0;
      check("reset_busy", {31'b0, Busy}, 0);
      check("reset_done", {31'b0, Done}, 0);
      check("reset_result", {16'b0, Result}, 0);
      check("reset_result_reg", {28'b0, ResultReg}, 0);
      check("reset_dbz", {31'b0, DivByZero}, 0);

      // Directed cases
      run_one(2'd0, 16'h1234, 16'h0010, 4'h1);
      run_one(2'd1, 16'h1234, 16'h0010, 4'h2);
      run_one(2'd1, 16'hFFFF, 16'hFFFF, 4'h3);
      run_one(2'd0, 16'hFFFF, 16'hFFFF, 4'h4);
      run_one(2'd2, 16'd100, 16'd7, 4'h5);
      run_one(2'd3, 16'd100, 16'd7, 4'h5);
      run_one(2'd2, 16'h0055, 16'h0000, 4'h6);
      run_one(2'd3, 16'h0055, 16'h0000, 4'h7);
      run_one(2'd0, 16'h00AB, 16'h0003, 4'h0);
      run_one(2'd2, 16'h0003, 16'h0009, 4'h8);

      // Start during RUN is ignored
      wait_idle();
      launch(2'd0, 16'h0101, 16'h0203, 4'h9, 1'b1);
      repeat (4) @(negedge Clk);
      Op = 2'd2; OpA = 16'h7777; OpB = 16'h0002; DestReg = 4'hE; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      wait_idle();

      // Reset on the 5th RUN cycle aborts the op with no Done
      launch(2'd3, 16'hBEEF, 16'h0011, 4'hA, 1'b0);
      repeat (4) @(negedge Clk);
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      check("abort_busy", {31'b0, Busy}, 0);
      check("abort_result", {16'b0, Result}, 0);
      check("abort_dbz", {31'b0, DivByZero}, 0);
      dcount = done_seen;
      repeat (20) @(negedge Clk);
      check("abort_no_done", done_seen - dcount, 0);

      // Back-to-back: second Start during the Done cycle
      launch(2'd2, 16'hFFFF, 16'h0010, 4'hB, 1'b1);
      wait_done();
      launch(2'd1, 16'h8000, 16'h0004, 4'hC, 1'b1);
      wait_idle();

      // Randomized operations, mixing idle gaps and back-to-back issue
      wait_idle();
      launch(2'($urandom), WIDTH'($urandom), WIDTH'($urandom), 4'($urandom), 1'b1);
      for (int i = 0; i < 40; i++) begin
         logic [WIDTH-1:0] rb;
         rb = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            wait_done();
         end else begin
            wait_idle();
         end
         launch(2'($urandom), WIDTH'($urandom), rb, 4'($urandom), 1'b1);
      end
      wait_idle();
      check("scoreboard_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
